// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that gives one drawing engine at a time the VGA adapter pixel port.
// The grant is held for a whole burst and muxes the granted engine's pixel onto registered adapter outputs.
module vga_draw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 8200
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done,
    input  logic [NUM_REQ*X_W-1:0]   x_in,
    input  logic [NUM_REQ*Y_W-1:0]   y_in,
    input  logic [NUM_REQ*C_W-1:0]   colour_in,
    input  logic [NUM_REQ-1:0]       plot_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [C_W-1:0]           colour,
    output logic                     plot,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t             state, state_next;
    logic [IW-1:0]      rr_ptr, rr_next;
    logic [IW-1:0]      owner, owner_next;
    logic [IW-1:0]      pick;
    logic               found;
    int                 idx;
    logic [HW-1:0]      hold_cnt, hold_next;
    logic [NUM_REQ-1:0] grant_next;
    logic               busy_next, terr_next, plot_next;
    logic [X_W-1:0]     x_next;
    logic [Y_W-1:0]     y_next;
    logic [C_W-1:0]     colour_next;
    logic               expired;
    logic               release_now;

    // Search starts at rr_ptr so the engine after the last owner gets first chance.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        busy_next   = busy;
        hold_next   = hold_cnt;
        rr_next     = rr_ptr;
        owner_next  = owner;
        terr_next   = timeout_err;
        plot_next   = 1'b0;
        x_next      = x;
        y_next      = y;
        colour_next = colour;
        expired     = 1'b0;
        release_now = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = NUM_REQ'(1) << pick;
                    busy_next  = 1'b1;
                    hold_next  = '0;
                    owner_next = pick;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                // Coordinates only move on a real write so the adapter sees stable values otherwise.
                plot_next = plot_in[owner] & grant[owner];
                if (plot_next) begin
                    x_next      = x_in[owner*X_W +: X_W];
                    y_next      = y_in[owner*Y_W +: Y_W];
                    colour_next = colour_in[owner*C_W +: C_W];
                end
                if (hold_cnt != {HW{1'b1}})
                    hold_next = hold_cnt + 1'b1;
                expired     = (hold_cnt == HW'(TIMEOUT - 1));
                release_now = done[owner] | ~req[owner] | expired;
                if (expired)
                    terr_next = 1'b1;
                if (release_now) begin
                    grant_next = '0;
                    busy_next  = 1'b0;
                    rr_next    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
            rr_ptr      <= '0;
            owner       <= '0;
            timeout_err <= 1'b0;
            plot        <= 1'b0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            busy        <= busy_next;
            hold_cnt    <= hold_next;
            rr_ptr      <= rr_next;
            owner       <= owner_next;
            timeout_err <= terr_next;
            plot        <= plot_next;
            x           <= x_next;
            y           <= y_next;
            colour      <= colour_next;
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: single burst, round robin, isolation, abandon, timeout, async reset.
// Runs with TIMEOUT=16 so the forced-revoke path is reachable in a short run.
module tb_vga_draw_arbiter;

    localparam int N  = 4;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] colour_in;
    logic [N-1:0]    plot_in;
    logic [N-1:0]    grant;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic            plot;
    logic            busy;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;
    int w;

    vga_draw_arbiter #(
        .NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
        .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic [XW-1:0] xv, input logic [YW-1:0] yv,
                                 input logic [CW-1:0] cv, input logic p);
        x_in[i*XW +: XW]      = xv;
        y_in[i*YW +: YW]      = yv;
        colour_in[i*CW +: CW] = cv;
        plot_in[i]            = p;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; done = '0; x_in = '0; y_in = '0; colour_in = '0; plot_in = '0;
        step(); step();
        reset = 1'b0;
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_plot", plot, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_x", x, 0);
        checkOutput("rst_terr", timeout_err, 0);

        // single requester, engine 2
        req = 4'b0100;
        step();
        checkOutput("single_grant", grant, 4'b0100);
        checkOutput("single_busy", busy, 1);
        applyStimulus(2, 100, 55, 3'd1, 1'b1);
        step();
        checkOutput("single_x0", x, 100);
        checkOutput("single_y0", y, 55);
        checkOutput("single_plot0", plot, 1);
        applyStimulus(2, 101, 55, 3'd1, 1'b1);
        step();
        checkOutput("single_x1", x, 101);
        applyStimulus(2, 102, 55, 3'd1, 1'b1);
        step();
        checkOutput("single_x2", x, 102);
        applyStimulus(2, 103, 55, 3'd1, 1'b1);
        done = 4'b0100;
        step();
        checkOutput("single_x3", x, 103);
        checkOutput("single_plot3", plot, 1);
        checkOutput("single_rel_grant", grant, 0);
        checkOutput("single_rel_busy", busy, 0);
        done = '0; req = '0; plot_in = '0;
        step();
        checkOutput("single_idle_plot", plot, 0);
        checkOutput("single_idle_grant", grant, 0);

        // round robin from a fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        step();
        for (int r = 0; r < 5; r++) begin
            w = r % N;
            checkOutput("rr_grant", grant, 32'd1 << w);
            step(); step();
            done = 4'b0001 << w;
            step();
            done = '0;
            checkOutput("rr_gap_grant", grant, 0);
            step();
            checkOutput("rr_idle_grant", grant, 0);
            checkOutput("rr_idle_plot", plot, 0);
            step();
        end
        checkOutput("rr_next", grant, 4'b0010);

        // abandon: engine 1 drops req, pointer moves to 2
        req = 4'b1101;
        step();
        checkOutput("abandon_rel", grant, 0);
        step();
        step();
        checkOutput("abandon_ptr", grant, 4'b0100);
        req = '0;
        step(); step();

        // isolation: engine 1 plots while engine 0 owns the port
        req = 4'b0001;
        applyStimulus(1, 7, 0, 3'b010, 1'b1);
        applyStimulus(0, 20, 10, 3'd5, 1'b1);
        step();
        checkOutput("iso_grant", grant, 4'b0001);
        checkOutput("iso_plot_pre", plot, 0);
        step();
        checkOutput("iso_x0", x, 20);
        checkOutput("iso_c0", colour, 5);
        checkOutput("iso_plot0", plot, 1);
        applyStimulus(0, 21, 10, 3'd5, 1'b0);
        done = 4'b0010;
        step();
        checkOutput("iso_done_other", grant, 4'b0001);
        checkOutput("iso_plot1", plot, 0);
        checkOutput("iso_x_hold", x, 20);
        done = '0;
        applyStimulus(0, 22, 10, 3'd6, 1'b1);
        step();
        checkOutput("iso_x2", x, 22);
        checkOutput("iso_c2", colour, 6);
        done = 4'b0001;
        step();
        checkOutput("iso_rel", grant, 0);
        done = '0; req = '0; plot_in = '0;
        step();

        // timeout: engine 3 never sends done
        req = 4'b1000;
        step();
        for (int i = 0; i < 16; i++) begin
            checkOutput("to_held", grant, 4'b1000);
            step();
        end
        checkOutput("to_revoked", grant, 0);
        checkOutput("to_err", timeout_err, 1);
        req = 4'b0001;
        applyStimulus(0, 30, 40, 3'd7, 1'b1);
        step();
        step();
        checkOutput("to_next_grant", grant, 4'b0001);
        checkOutput("to_err_sticky", timeout_err, 1);
        step();
        checkOutput("ar_plot_before", plot, 1);
        checkOutput("ar_x_before", x, 30);

        // asynchronous reset pulse mid-cycle
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_plot", plot, 0);
        checkOutput("ar_grant", grant, 0);
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_terr", timeout_err, 0);
        #2 reset = 1'b0;
        req = 4'b0011;
        step();
        checkOutput("ar_rr_restart", grant, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
